// File: rtl/modn_cnt_pkg.sv
// Shared constants for the mod-N up/down counter: count direction and boundary mode.
package modn_cnt_pkg;
   localparam bit DIR_UP    = 1'b1;
   localparam bit DIR_DN    = 1'b0;
   localparam int MODE_WRAP = 0;
   localparam int MODE_SAT  = 1;
endpackage

// File: rtl/mod_n_updown_counter.sv
// Mod-N up/down counter with parallel load, wrap or saturate at the boundary, and cascade carry.
// Define MODN_CNT_LOAD_CHECK_EN to get a sticky load_err flag for out-of-range loads.
module mod_n_updown_counter
   import modn_cnt_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int MOD   = 47,
   parameter int SAT   = MODE_WRAP
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap,
   output logic             load_err
);

   generate
      if (MOD < 2 || MOD > (2 ** WIDTH)) begin : g_bad_mod
         $error("mod_n_updown_counter: MOD must lie in 2..2**WIDTH");
      end
   endgenerate

   // State is held one bit wider so MOD = 2**WIDTH compares cleanly; the top bit is always 0.
   localparam logic [WIDTH:0] TOP   = (WIDTH+1)'(MOD - 1);
   localparam logic [WIDTH:0] MOD_W = (WIDTH+1)'(MOD);

   logic [WIDTH:0] cnt_q;
   logic [WIDTH:0] cnt_nxt;
   logic [WIDTH:0] data_w;
   logic           at_top;
   logic           at_bot;
   logic           load_ok;

   assign data_w  = {1'b0, data};
   assign at_top  = (cnt_q == TOP);
   assign at_bot  = (cnt_q == '0);
   assign load_ok = (data_w < MOD_W);
   assign count   = cnt_q[WIDTH-1:0];
   assign tc      = en & ~load & ((up_dn == DIR_UP) ? at_top : at_bot);

   always_comb begin
      cnt_nxt = cnt_q;
      if (load) begin
         if (load_ok) cnt_nxt = data_w;
      end else if (en) begin
         if (up_dn == DIR_UP) begin
            if (at_top) cnt_nxt = (SAT == MODE_SAT) ? TOP : '0;
            else        cnt_nxt = cnt_q + 1'b1;
         end else begin
            if (at_bot) cnt_nxt = (SAT == MODE_SAT) ? '0 : TOP;
            else        cnt_nxt = cnt_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
         wrap  <= 1'b0;
      end else begin
         cnt_q <= cnt_nxt;
         wrap  <= tc;
      end
   end

`ifdef MODN_CNT_LOAD_CHECK_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                load_err <= 1'b0;
      else if (load && !load_ok) load_err <= 1'b1;
   end
`else
   assign load_err = 1'b0;
`endif

endmodule

// File: doc/mod_n_updown_counter.md
MOD_N_UPDOWN_COUNTER -- requirements
Module: mod_n_updown_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the width of data and count.
REQ-002 The block SHALL have parameter MOD, default 47, giving the modulus, legal range 2..2**WIDTH.
REQ-003 The block SHALL have parameter SAT, default 0, where 0 means wrap at the boundary and 1 means saturate at the boundary.
REQ-004 The block SHALL have port clk, input, 1 bit: the single rising-edge clock.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port en, input, 1 bit: count enable.
REQ-007 The block SHALL have port up_dn, input, 1 bit: 1 counts up, 0 counts down.
REQ-008 The block SHALL have port load, input, 1 bit: synchronous parallel load strobe.
REQ-009 The block SHALL have port data, input, WIDTH bits: the load value.
REQ-010 The block SHALL have port count, output, WIDTH bits: the registered count value.
REQ-011 The block SHALL have port tc, output, 1 bit: combinational terminal-count indicator.
REQ-012 The block SHALL have port wrap, output, 1 bit: registered one-cycle pulse on a boundary event.
REQ-013 The block SHALL have port load_err, output, 1 bit: sticky out-of-range load flag.

Function
REQ-014 count SHALL always lie in the range 0..MOD-1.
REQ-015 Priority per rising clk edge SHALL be load first, then en, then hold.
REQ-016 When load=1 and data<MOD, count SHALL take the value of data on the next edge, regardless of en.
REQ-017 When load=1 and data>=MOD, count SHALL hold (the load is rejected); see REQ-026 and REQ-027 for load_err.
REQ-018 When en=1, load=0 and up_dn=1:
- count SHALL increment by 1.
- At MOD-1, count SHALL go to 0 if SAT=0, or stay at MOD-1 if SAT=1.
REQ-019 When en=1, load=0 and up_dn=0:
- count SHALL decrement by 1.
- At 0, count SHALL go to MOD-1 if SAT=0, or stay at 0 if SAT=1.
REQ-020 tc SHALL equal en AND (up_dn ? count==MOD-1 : count==0), and SHALL be 0 whenever load=1.
REQ-021 wrap SHALL be 1 for exactly the one cycle after an edge on which tc was 1, in both SAT modes; it is a cascade carry/borrow.
REQ-022 Changing up_dn between cycles SHALL take effect on the very next enabled edge, with no dead cycle.
REQ-023 Next-count arithmetic SHALL be computed at WIDTH+1 bits, so that MOD=2**WIDTH never overflows the compare.

Reset
REQ-024 While rst=0, count SHALL be 0, wrap SHALL be 0 and load_err SHALL be 0, asynchronously and independent of clk.
REQ-025 Reset SHALL take precedence over load and en; the first edge after rst deasserts SHALL act normally.

Configuration
REQ-026 With MODN_CNT_LOAD_CHECK_EN defined, a rejected load (data>=MOD) SHALL set load_err on the next edge, and load_err SHALL stay 1 until rst.
REQ-027 Without MODN_CNT_LOAD_CHECK_EN, load_err SHALL be tied to 0 and rejected loads SHALL be silently ignored; count still holds.

Structure
REQ-028 Package modn_cnt_pkg SHALL hold the direction constants DIR_UP=1 and DIR_DN=0 and the mode constants MODE_WRAP=0 and MODE_SAT=1.
REQ-029 The block SHALL be a single module with no sub-module, since next-state logic and registers fit in one unit.
REQ-030 The block SHALL include an elaboration-time check that MOD lies in 2..2**WIDTH.

Verification
REQ-031 Defaults: rst=0 for 12 ns, then rst=1 with en=1, up_dn=1 for 50 clocks -> count runs 0..46, then 0, 1, 2; tc is 1 at 46; wrap is 1 on the cycle count=0.
REQ-032 Down wrap: load data=3, then en=1, up_dn=0 -> count runs 3,2,1,0,46,45; wrap pulses once.
REQ-033 SAT=1, MOD=10: count up for 15 clocks -> count holds at 9; tc stays 1; wrap pulses on every held edge.
REQ-034 load=1 with en=1, data=20 on the same edge -> count=20 on the next edge; no increment is applied.
REQ-035 Out-of-range load: load data=50 with MOD=47 -> count holds. With the macro, load_err=1 and sticky until rst; without it, load_err=0.
REQ-036 Assert rst=0 mid-count at count=30, between clock edges -> count=0 immediately; after release, counting resumes from 0.
